// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: bus widths, bus field layouts and FSM encodings.
// The bus structs mirror the myCPU.h bit offsets, MSB first.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 87;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_FORWARD_WD   = 72;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_DONE = 2'd2
    } ms_state_e;

    typedef struct packed {
        logic [3:0]  mul_div_op;
        logic        mul_div_sign;
        logic [1:0]  addr_lo;
        logic        mem_we;
        logic        ld_hu;
        logic        ld_h;
        logic        ld_bu;
        logic        ld_b;
        logic        ld_w;
        logic        st_h;
        logic        st_b;
        logic        st_w;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_bus_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_bus_t;

    typedef struct packed {
        logic        data_pending;
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  dest;
        logic        gr_we;
        logic        valid;
    } ms_forward_t;

    function automatic logic is_mem_op(input es_to_ms_bus_t b);
        return b.res_from_mem || b.mem_we;
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Load data extraction: selects the addressed byte or halfword of a read word
// and sign- or zero-extends it to 32 bits.
module mem_stage_load_ext (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic        ld_b,
    input  logic        ld_bu,
    input  logic        ld_h,
    input  logic        ld_hu,
    input  logic        ld_w,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = '0;
        if (ld_w)       data = rdata;
        else if (ld_b)  data = {{24{byte_sel[7]}}, byte_sel};
        else if (ld_bu) data = {24'd0, byte_sel};
        else if (ld_h)  data = {{16{half_sel[15]}}, half_sel};
        else if (ld_hu) data = {16'd0, half_sel};
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: waits for the data-SRAM response of loads/stores, extends load data,
// selects mul/div results and holds one completed response while writeback stalls.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FORWARD_WD-1:0]   ms_forward,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic [63:0]                mul_result,
    input  logic [31:0]                div_quotient,
    input  logic [31:0]                div_remainder
);

    es_to_ms_bus_t es_bus, bus_q, bus_d;
    ms_state_e     state_q, state_d;
    logic          ms_valid_q, ms_valid_d;
    logic [31:0]   rdata_buf_q, rdata_buf_d;

    logic          need_resp;
    logic          ms_ready_go;
    logic          mem_enter;
    logic          capture;
    logic [31:0]   load_src;
    logic [31:0]   load_data;
    logic [31:0]   final_result;
    logic          out_gr_we;
    ms_to_ws_bus_t ws_bus;
    ms_forward_t   fwd;

    assign es_bus = es_to_ms_bus_t'(es_to_ms_bus);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= MS_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MS_IDLE: if (mem_enter) state_d = MS_WAIT;
            MS_WAIT: begin
                if (data_sram_data_ok) begin
                    if (!ws_allowin)    state_d = MS_DONE;
                    else if (mem_enter) state_d = MS_WAIT;
                    else                state_d = MS_IDLE;
                end
            end
            MS_DONE: begin
                if (ws_allowin) state_d = mem_enter ? MS_WAIT : MS_IDLE;
            end
            default: state_d = MS_IDLE;
        endcase
    end

    always_comb begin
        need_resp      = ms_valid_q && is_mem_op(bus_q);
        ms_ready_go    = !need_resp || (state_q == MS_DONE)
                         || ((state_q == MS_WAIT) && data_sram_data_ok);
        ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
        ms_to_ws_valid = ms_valid_q && ms_ready_go;
        mem_enter      = es_to_ms_valid && ms_allowin && is_mem_op(es_bus);
        capture        = (state_q == MS_WAIT) && data_sram_data_ok && !ws_allowin;
    end

    always_comb begin
        ms_valid_d  = ms_allowin ? es_to_ms_valid : ms_valid_q;
        bus_d       = (es_to_ms_valid && ms_allowin) ? es_bus : bus_q;
        rdata_buf_d = capture ? data_sram_rdata : rdata_buf_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_valid_q  <= 1'b0;
            bus_q       <= '0;
            rdata_buf_q <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            bus_q       <= bus_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    // Once writeback has stalled a response, the live SRAM data bus is no longer trusted.
    assign load_src = (state_q == MS_DONE) ? rdata_buf_q : data_sram_rdata;

    mem_stage_load_ext u_load_ext (
        .rdata   (load_src),
        .addr_lo (bus_q.addr_lo),
        .ld_b    (bus_q.ld_b),
        .ld_bu   (bus_q.ld_bu),
        .ld_h    (bus_q.ld_h),
        .ld_hu   (bus_q.ld_hu),
        .ld_w    (bus_q.ld_w),
        .data    (load_data)
    );

    always_comb begin
        final_result = bus_q.alu_result;
        if (bus_q.res_from_mem)       final_result = load_data;
        else if (bus_q.mul_div_op[0]) final_result = mul_result[31:0];
        else if (bus_q.mul_div_op[1]) final_result = mul_result[63:32];
        else if (bus_q.mul_div_op[2]) final_result = div_quotient;
        else if (bus_q.mul_div_op[3]) final_result = div_remainder;
    end

    assign out_gr_we = bus_q.gr_we && !bus_q.mem_we;

    always_comb begin
        ws_bus              = '0;
        ws_bus.gr_we        = out_gr_we;
        ws_bus.dest         = bus_q.dest;
        ws_bus.final_result = final_result;
        ws_bus.pc           = bus_q.pc;

        fwd                 = '0;
        fwd.valid           = ms_valid_q;
        fwd.gr_we           = out_gr_we;
        fwd.dest            = bus_q.dest;
        fwd.result          = final_result;
        fwd.pc              = bus_q.pc;
        fwd.data_pending    = need_resp && !ms_ready_go;
    end

    assign ms_to_ws_bus = ws_bus;
    assign ms_forward   = fwd;

    logic unused_bits;
    assign unused_bits = ^{bus_q.mul_div_sign, bus_q.st_h, bus_q.st_b, bus_q.st_w};

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: a transaction-level model checks every cycle,
// literal expectations pin the key scenarios.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        es_to_ms_valid = 1'b0;
    logic [86:0] es_to_ms_bus = '0;
    logic        ms_allowin;
    logic        ws_allowin = 1'b1;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [71:0] ms_forward;
    logic        data_sram_data_ok = 1'b0;
    logic [31:0] data_sram_rdata = '0;
    logic [63:0] mul_result = 64'h0000_0003_0000_0009;
    logic [31:0] div_quotient = 32'h0000_0011;
    logic [31:0] div_remainder = 32'h0000_0007;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [4:0] LD_W  = 5'b00001;
    localparam logic [4:0] LD_B  = 5'b00010;
    localparam logic [4:0] LD_BU = 5'b00100;
    localparam logic [4:0] LD_H  = 5'b01000;
    localparam logic [4:0] LD_HU = 5'b10000;
    localparam logic [2:0] ST_W  = 3'b001;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_forward        (ms_forward),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .mul_result        (mul_result),
        .div_quotient      (div_quotient),
        .div_remainder     (div_remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [86:0] mk(input logic [31:0] pc, input logic [31:0] alu,
                                       input logic [4:0] dest, input logic gr_we,
                                       input logic rfm, input logic [2:0] st,
                                       input logic [4:0] ld, input logic mem_we,
                                       input logic [1:0] addr, input logic [3:0] op);
        return {op, 1'b0, addr, mem_we, ld, st, rfm, gr_we, dest, alu, pc};
    endfunction

    // Expected writeback value computed from the instruction's fields with plain arithmetic.
    function automatic logic [31:0] exp_result(input logic [86:0] b, input logic [31:0] rd);
        int          a;
        logic [31:0] by;
        logic [31:0] hw;
        logic [31:0] r;
        a  = int'(b[81:80]);
        by = (rd >> (8 * a)) & 32'h0000_00FF;
        hw = (rd >> (16 * (a / 2))) & 32'h0000_FFFF;
        if (b[70]) begin
            if (b[74])      r = rd;
            else if (b[75]) r = (by >= 32'd128) ? by + 32'hFFFF_FF00 : by;
            else if (b[76]) r = by;
            else if (b[77]) r = (hw >= 32'd32768) ? hw + 32'hFFFF_0000 : hw;
            else            r = hw;
        end
        else if (b[83]) r = mul_result[31:0];
        else if (b[84]) r = mul_result[63:32];
        else if (b[85]) r = div_quotient;
        else if (b[86]) r = div_remainder;
        else            r = b[63:32];
        return r;
    endfunction

    // Model: one held instruction, whether its response already arrived, and the saved data.
    logic [86:0] m_instr = '0;
    bit          m_valid = 1'b0;
    bit          m_got   = 1'b0;
    logic [31:0] m_saved = '0;

    initial begin
        bit          need, ready, e_out, e_allow;
        logic [31:0] res;
        forever begin
            @(negedge clk);
            if (!reset) begin
                m_valid = 1'b0;
                m_got   = 1'b0;
                check("m_rst_allowin", 32'(ms_allowin), 32'd1);
                check("m_rst_valid",   32'(ms_to_ws_valid), 32'd0);
                check("m_rst_fwd0",    32'(ms_forward[0]), 32'd0);
                check("m_rst_fwd71",   32'(ms_forward[71]), 32'd0);
            end else begin
                need    = m_valid && (m_instr[70] || m_instr[79]);
                ready   = !need || m_got || data_sram_data_ok;
                e_out   = m_valid && ready;
                e_allow = !m_valid || (ready && ws_allowin);
                check("m_allowin", 32'(ms_allowin), 32'(e_allow));
                check("m_valid",   32'(ms_to_ws_valid), 32'(e_out));
                check("m_fwd0",    32'(ms_forward[0]), 32'(m_valid));
                check("m_fwd71",   32'(ms_forward[71]), 32'(need && !ready));
                if (e_out) begin
                    res = exp_result(m_instr, m_got ? m_saved : data_sram_rdata);
                    check("m_pc",       ms_to_ws_bus[31:0], m_instr[31:0]);
                    check("m_result",   ms_to_ws_bus[63:32], res);
                    check("m_dest",     32'(ms_to_ws_bus[68:64]), 32'(m_instr[68:64]));
                    check("m_gr_we",    32'(ms_to_ws_bus[69]), 32'(m_instr[69] && !m_instr[79]));
                    check("m_fwd_res",  ms_forward[38:7], res);
                    check("m_fwd_dest", 32'(ms_forward[6:2]), 32'(m_instr[68:64]));
                    check("m_fwd_pc",   ms_forward[70:39], m_instr[31:0]);
                end
                if (need && !m_got && data_sram_data_ok && !ws_allowin) begin
                    m_got   = 1'b1;
                    m_saved = data_sram_rdata;
                end
                if (e_allow) begin
                    m_valid = es_to_ms_valid;
                    if (es_to_ms_valid) begin
                        m_instr = es_to_ms_bus;
                        m_got   = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [4:0]  sw_ld   [3] = '{LD_H, LD_BU, LD_H};
    logic [1:0]  sw_addr [3] = '{2'd2, 2'd1, 2'd0};
    logic [31:0] sw_rd   [3] = '{32'h8001_55AA, 32'h0000_9A00, 32'hFFFF_7FFF};
    logic [31:0] sw_exp  [3] = '{32'hFFFF_8001, 32'h0000_009A, 32'h0000_7FFF};
    logic [3:0]  op_list [3] = '{4'b0001, 4'b0100, 4'b0000};

    initial begin
        #3;
        check("rst_allowin", 32'(ms_allowin), 32'd1);
        check("rst_valid",   32'(ms_to_ws_valid), 32'd0);
        check("rst_fwd71",   32'(ms_forward[71]), 32'd0);
        repeat (2) step();
        reset = 1'b1;
        step();

        // ld_b, data_ok in the entry cycle
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1c00_0000, 32'h0000_1003, 5'd5, 1'b1, 1'b1, 3'b0, LD_B, 1'b0, 2'b11, 4'b0);
        step();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_0000;
        #2;
        check("ldb_valid",  32'(ms_to_ws_valid), 32'd1);
        check("ldb_result", ms_to_ws_bus[63:32], 32'hFFFF_FF80);
        check("ldb_gr_we",  32'(ms_to_ws_bus[69]), 32'd1);
        step();
        data_sram_data_ok = 1'b0;

        // ld_hu, data_ok three cycles late, followed back-to-back by another load
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1c00_0004, 32'h0000_2002, 5'd6, 1'b1, 1'b1, 3'b0, LD_HU, 1'b0, 2'b10, 4'b0);
        step();
        es_to_ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("ldhu_wait_valid", 32'(ms_to_ws_valid), 32'd0);
            check("ldhu_wait_fwd71", 32'(ms_forward[71]), 32'd1);
            step();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h8001_1234;
        es_to_ms_valid    = 1'b1;
        es_to_ms_bus      = mk(32'h1c00_0008, 32'h0000_3000, 5'd8, 1'b1, 1'b1, 3'b0, LD_B, 1'b0, 2'b00, 4'b0);
        #2;
        check("ldhu_result", ms_to_ws_bus[63:32], 32'h0000_8001);
        step();
        es_to_ms_valid  = 1'b0;
        data_sram_rdata = 32'h0000_007F;
        #2;
        check("b2b_result", ms_to_ws_bus[63:32], 32'h0000_007F);
        check("b2b_state",  32'(dut.state_q), 32'd1);
        step();
        data_sram_data_ok = 1'b0;

        // ld_w with writeback stalled: response must be held
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1c00_000c, 32'h0000_4000, 5'd7, 1'b1, 1'b1, 3'b0, LD_W, 1'b0, 2'b00, 4'b0);
        step();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1234_5678;
        ws_allowin        = 1'b0;
        #2;
        check("ldw_valid",   32'(ms_to_ws_valid), 32'd1);
        check("ldw_allowin", 32'(ms_allowin), 32'd0);
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #2;
        check("ldw_state_done", 32'(dut.state_q), 32'd2);
        check("ldw_held",       ms_to_ws_bus[63:32], 32'h1234_5678);
        step();
        ws_allowin      = 1'b1;
        data_sram_rdata = 32'hFFFF_FFFF;
        #2;
        check("ldw_release", ms_to_ws_bus[63:32], 32'h1234_5678);
        step();
        #2;
        check("ldw_state_idle", 32'(dut.state_q), 32'd0);
        data_sram_data_ok = 1'b1;
        #1;
        check("stray_idle_valid", 32'(ms_to_ws_valid), 32'd0);
        step();
        data_sram_data_ok = 1'b0;
        check("stray_idle_state", 32'(dut.state_q), 32'd0);

        // st_w, response one cycle late
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1c00_0010, 32'h0000_5000, 5'd0, 1'b0, 1'b0, ST_W, 5'b0, 1'b1, 2'b00, 4'b0);
        step();
        es_to_ms_valid = 1'b0;
        #2;
        check("st_allowin_lo", 32'(ms_allowin), 32'd0);
        step();
        data_sram_data_ok = 1'b1;
        #2;
        check("st_valid", 32'(ms_to_ws_valid), 32'd1);
        check("st_gr_we", 32'(ms_to_ws_bus[69]), 32'd0);
        step();
        data_sram_data_ok = 1'b0;

        // mul/div selection, no data_ok needed
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1c00_0014, 32'h0000_AAAA, 5'd9, 1'b1, 1'b0, 3'b0, 5'b0, 1'b0, 2'b00, 4'b0010);
        step();
        es_to_ms_bus   = mk(32'h1c00_0018, 32'h0000_BBBB, 5'd10, 1'b1, 1'b0, 3'b0, 5'b0, 1'b0, 2'b00, 4'b1000);
        #2;
        check("mulh_result", ms_to_ws_bus[63:32], 32'h0000_0003);
        step();
        es_to_ms_valid = 1'b0;
        #2;
        check("mod_result", ms_to_ws_bus[63:32], 32'h0000_0007);
        for (int i = 0; i < 3; i++) begin
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = mk(32'h1c00_0020 + 32'(4 * i), 32'h0000_C000 + 32'(i), 5'(11 + i),
                                1'b1, 1'b0, 3'b0, 5'b0, 1'b0, 2'b00, op_list[i]);
            step();
        end
        es_to_ms_valid = 1'b0;
        step();

        // load extension sweep
        for (int i = 0; i < 3; i++) begin
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = mk(32'h1c00_0040 + 32'(4 * i), 32'h0000_6000, 5'(20 + i),
                                1'b1, 1'b1, 3'b0, sw_ld[i], 1'b0, sw_addr[i], 4'b0);
            step();
            es_to_ms_valid    = 1'b0;
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = sw_rd[i];
            #2;
            check("sweep_result", ms_to_ws_bus[63:32], sw_exp[i]);
            step();
            data_sram_data_ok = 1'b0;
        end

        // reset pulsed mid-wait, then a late data_ok
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(32'h1c00_0050, 32'h0000_7000, 5'd30, 1'b1, 1'b1, 3'b0, LD_W, 1'b0, 2'b00, 4'b0);
        step();
        es_to_ms_valid = 1'b0;
        #2;
        check("rw_fwd71", 32'(ms_forward[71]), 32'd1);
        reset = 1'b0;
        #1;
        check("rw_allowin", 32'(ms_allowin), 32'd1);
        check("rw_valid",   32'(ms_to_ws_valid), 32'd0);
        check("rw_fwd0",    32'(ms_forward[0]), 32'd0);
        step();
        reset = 1'b1;
        step();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_ABCD;
        #2;
        check("late_ok_valid", 32'(ms_to_ws_valid), 32'd0);
        step();
        data_sram_data_ok = 1'b0;
        #2;
        check("late_ok_state", 32'(dut.state_q), 32'd0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
